// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered 8N1 UART transmitter with CTS flow control.
// Bytes enter a DEPTH-entry FIFO over a valid/ready port. Each byte is
// sent LSB-first as start(0), 8 data bits and stop(1). Every bit lasts
// max(cfg_div,2) clocks, and that value is latched once per frame.
// Ports:
//   clk, resetn      system clock, asynchronous active-low reset
//   cfg_div          clocks per bit (0 and 1 are treated as 2)
//   wr_valid/wr_data write request and byte
//   wr_ready         FIFO not full (from registered state only)
//   ser_cts_n        remote clear-to-send, active low, asynchronous
//   ser_tx           serial line, idle high, driven from a flop
//   tx_busy          frame in progress or FIFO not empty (registered)
//   fifo_level       current FIFO occupancy
module uart_tx_fifo #(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned DIV_RESET = 106
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [31:0]              cfg_div,
  input  logic                     wr_valid,
  input  logic [7:0]               wr_data,
  output logic                     wr_ready,
  input  logic                     ser_cts_n,
  output logic                     ser_tx,
  output logic                     tx_busy,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE      = (AW+1)'(1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wptr, rptr, level, level_n;
  logic        full, empty, push, pop;
  logic [1:0]  cts_sync;
  logic        cts_ok;

  logic [1:0]  state, state_n;
  logic [31:0] cnt, cnt_n;
  logic [31:0] eff_div, eff_div_n, cfg_eff;
  logic [2:0]  bit_idx, bit_idx_n;
  logic [7:0]  shift, shift_n;
  logic        ser_tx_n, busy_n;

  assign level      = wptr - rptr;
  assign full       = (level == FULL_LVL);
  assign empty      = (level == '0);
  assign wr_ready   = !full;
  assign fifo_level = level;
  assign push       = wr_valid && !full;
  assign cts_ok     = !cts_sync[1];
  assign pop        = (state == ST_IDLE) && !empty && cts_ok;
  assign cfg_eff    = (cfg_div < 32'd2) ? 32'd2 : cfg_div;

  always_comb begin
    level_n = level;
    case ({push, pop})
      2'b10:   level_n = level + ONE;
      2'b01:   level_n = level - ONE;
      default: level_n = level;
    endcase
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    eff_div_n = eff_div;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    case (state)
      ST_IDLE: begin
        if (pop) begin
          shift_n   = mem[rptr[AW-1:0]];
          eff_div_n = cfg_eff;
          cnt_n     = cfg_eff - 32'd1;
          state_n   = ST_START;
        end
      end
      ST_START: begin
        if (cnt == '0) begin
          state_n   = ST_DATA;
          bit_idx_n = '0;
          cnt_n     = eff_div - 32'd1;
        end else begin
          cnt_n = cnt - 32'd1;
        end
      end
      ST_DATA: begin
        if (cnt == '0) begin
          shift_n = {1'b0, shift[7:1]};
          cnt_n   = eff_div - 32'd1;
          if (bit_idx == 3'd7) state_n = ST_STOP;
          else                 bit_idx_n = bit_idx + 3'd1;
        end else begin
          cnt_n = cnt - 32'd1;
        end
      end
      ST_STOP: begin
        if (cnt == '0) state_n = ST_IDLE;
        else           cnt_n   = cnt - 32'd1;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // The line flop follows the current state, so ser_tx trails the FSM by
  // one cycle; this yields the write-to-start latency of two cycles.
  always_comb begin
    ser_tx_n = 1'b1;
    if (state == ST_START)     ser_tx_n = 1'b0;
    else if (state == ST_DATA) ser_tx_n = shift[0];
  end

  // Busy is registered from next-cycle state so it tracks the FSM/FIFO
  // without a combinational output path.
  assign busy_n = (state_n != ST_IDLE) || (level_n != '0);

  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr     <= '0;
      rptr     <= '0;
      cts_sync <= '1;
      state    <= ST_IDLE;
      cnt      <= '0;
      eff_div  <= DIV_RESET;
      bit_idx  <= '0;
      shift    <= '0;
      ser_tx   <= 1'b1;
      tx_busy  <= 1'b0;
    end else begin
      if (push) wptr <= wptr + ONE;
      if (pop)  rptr <= rptr + ONE;
      cts_sync <= {cts_sync[0], ser_cts_n};
      state    <= state_n;
      cnt      <= cnt_n;
      eff_div  <= eff_div_n;
      bit_idx  <= bit_idx_n;
      shift    <= shift_n;
      ser_tx   <= ser_tx_n;
      tx_busy  <= busy_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed testbench for uart_tx_fifo: waveform timing, FIFO overflow,
// CTS gating, divider clamp/latch, write-at-full, and reset mid-frame.
module tb_uart_tx_fifo;

  logic        clk;
  logic        resetn;
  logic [31:0] cfg_div;
  logic        wr_valid;
  logic [7:0]  wr_data;
  logic        wr_ready;
  logic        ser_cts_n;
  logic        ser_tx;
  logic        tx_busy;
  logic [4:0]  fifo_level;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned cyc = 0;
  int unsigned mon_div = 106;

  logic [9:0]  rx_q[$];
  int unsigned rx_cyc_q[$];

  uart_tx_fifo #(.DEPTH(16), .DIV_RESET(106)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .cfg_div    (cfg_div),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .ser_cts_n  (ser_cts_n),
    .ser_tx     (ser_tx),
    .tx_busy    (tx_busy),
    .fifo_level (fifo_level)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Line receiver: samples each bit at its midpoint using mon_div; a frame
  // interrupted by reset is discarded.
  initial begin : monitor
    int unsigned s0, d, tgt;
    logic [9:0]  bits;
    logic        ab;
    forever begin
      @(negedge clk);
      if (resetn && ser_tx == 1'b0) begin
        s0 = cyc; d = mon_div; ab = 1'b0; bits = '0;
        for (int k = 0; k < 10; k++) begin
          tgt = k * d + d / 2;
          while (!ab && (cyc - s0) < tgt) begin
            @(negedge clk);
            if (!resetn) ab = 1'b1;
          end
          bits[k] = ser_tx;
        end
        if (!ab) begin
          rx_q.push_back(bits);
          rx_cyc_q.push_back(s0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b, output logic acc);
    wr_valid = 1'b1;
    wr_data  = b;
    acc      = wr_ready;
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
  endtask

  task automatic wait_rx(input string tag, input int unsigned tmo,
                         output logic [9:0] fr, output int unsigned sc);
    int unsigned n = 0;
    while (rx_q.size() == 0 && n < tmo) begin
      @(posedge clk);
      n++;
    end
    check({tag, "_arrive"}, 32'(rx_q.size() != 0), 32'd1);
    if (rx_q.size() != 0) begin
      fr = rx_q.pop_front();
      sc = rx_cyc_q.pop_front();
    end else begin
      fr = '0;
      sc = 0;
    end
  endtask

  function automatic logic [9:0] frame_of(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction

  initial begin : main
    logic        acc;
    logic [9:0]  fr;
    int unsigned sc, prev, c0, n, lows, errs, idx, accepted;
    logic [9:0]  expf;
    logic [7:0]  b;

    resetn = 1'b1; ser_cts_n = 1'b1; wr_valid = 1'b0; wr_data = '0; cfg_div = 32'd106;
    #2 resetn = 1'b0;
    #2;
    check("rst_ser_tx", 32'(ser_tx), 32'd1);
    check("rst_busy", 32'(tx_busy), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_wr_ready", 32'(wr_ready), 32'd1);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    ser_cts_n = 1'b0;
    repeat (4) tick();

    // Single byte 'A' at 106 clocks per bit, checked cycle by cycle
    push_byte(8'h41, acc);
    check("t1_accept", 32'(acc), 32'd1);
    expf = frame_of(8'h41);
    errs = 0;
    for (int k = 1; k <= 1063; k++) begin
      @(negedge clk);
      if (k == 1) check("t1_level_after_write", 32'(fifo_level), 32'd1);
      if (k == 2) begin
        check("t1_level_after_pop", 32'(fifo_level), 32'd0);
        check("t1_still_idle", 32'(ser_tx), 32'd1);
      end
      if (k == 3) check("t1_start_latency", 32'(ser_tx), 32'd0);
      if (k == 1061) check("t1_busy_last", 32'(tx_busy), 32'd1);
      if (k == 1062) check("t1_busy_drop", 32'(tx_busy), 32'd0);
      if (k >= 3 && k <= 1062) begin
        idx = (k - 3) / 106;
        if (ser_tx !== expf[idx]) errs++;
      end else if (ser_tx !== 1'b1) errs++;
    end
    check("t1_wave_errs", errs, 32'd0);
    wait_rx("t1_rx", 100, fr, sc);
    check("t1_rx_byte", 32'(fr), 32'(frame_of(8'h41)));

    // FIFO full / overflow with CTS held off
    ser_cts_n = 1'b1;
    repeat (3) tick();
    accepted = 0;
    for (int i = 0; i < 16; i++) begin
      push_byte(8'(i), acc);
      if (acc) accepted++;
    end
    check("t2_accepted16", accepted, 32'd16);
    check("t2_full_ready", 32'(wr_ready), 32'd0);
    check("t2_full_level", 32'(fifo_level), 32'd16);
    push_byte(8'h10, acc);
    check("t2_overflow_rejected", 32'(acc), 32'd0);
    check("t2_level_unchanged", 32'(fifo_level), 32'd16);
    ser_cts_n = 1'b0;
    prev = 0; errs = 0;
    for (int i = 0; i < 16; i++) begin
      wait_rx("t2_rx", 2000, fr, sc);
      if (fr !== frame_of(8'(i))) errs++;
      if (i > 0 && (sc - prev) != 1061) errs++;
      prev = sc;
    end
    check("t2_frames_and_pitch_errs", errs, 32'd0);
    repeat (60) tick();
    check("t2_level_empty", 32'(fifo_level), 32'd0);
    check("t2_busy_idle", 32'(tx_busy), 32'd0);

    // CTS deasserted mid-frame
    cfg_div = 32'd16; mon_div = 16;
    push_byte(8'h55, acc);
    push_byte(8'hAA, acc);
    n = 0;
    do begin @(negedge clk); n++; end while (ser_tx !== 1'b0 && n < 50);
    check("t3_start_seen", 32'(ser_tx), 32'd0);
    repeat (4 * 16 + 8) @(negedge clk);
    ser_cts_n = 1'b1;
    wait_rx("t3_rx55", 400, fr, sc);
    check("t3_byte55", 32'(fr), 32'(frame_of(8'h55)));
    lows = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (ser_tx !== 1'b1) lows++;
    end
    check("t3_held_by_cts", lows, 32'd0);
    check("t3_aa_queued", 32'(fifo_level), 32'd1);
    check("t3_busy_while_held", 32'(tx_busy), 32'd1);
    ser_cts_n = 1'b0;
    c0 = cyc;
    wait_rx("t3_rxAA", 400, fr, sc);
    check("t3_cts_lat_3_to_4", 32'((sc - c0) >= 3 && (sc - c0) <= 4), 32'd1);
    check("t3_byteAA", 32'(fr), 32'(frame_of(8'hAA)));
    repeat (20) tick();

    // Divider clamp and per-frame latch
    cfg_div = 32'd0; mon_div = 2;
    push_byte(8'hFF, acc);
    push_byte(8'h01, acc);
    cfg_div = 32'd10;
    wait_rx("t4_rxFF", 100, fr, prev);
    check("t4_byteFF", 32'(fr), 32'(frame_of(8'hFF)));
    mon_div = 10;
    wait_rx("t4_rx01", 200, fr, sc);
    check("t4_byte01", 32'(fr), 32'(frame_of(8'h01)));
    check("t4_pitch_div2", sc - prev, 32'd21);
    n = 0;
    do begin @(negedge clk); n++; end while (cyc < sc + 98 && n < 50);
    check("t4_busy_before_end", 32'(tx_busy), 32'd1);
    @(negedge clk);
    check("t4_busy_at_frame100", 32'(tx_busy), 32'd0);
    check("t4_line_high", 32'(ser_tx), 32'd1);
    repeat (5) tick();

    // Write rejected in the cycle a pop frees a slot, accepted next cycle
    cfg_div = 32'd2; mon_div = 2;
    ser_cts_n = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < 16; i++) push_byte(8'(8'h20 + i), acc);
    check("t5_full_level", 32'(fifo_level), 32'd16);
    @(negedge clk);
    ser_cts_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("t5_ready_before_pop", 32'(wr_ready), 32'd0);
    wr_valid = 1'b1; wr_data = 8'h99;
    @(negedge clk);
    check("t5_level_after_pop", 32'(fifo_level), 32'd15);
    check("t5_ready_after_pop", 32'(wr_ready), 32'd1);
    @(negedge clk);
    wr_valid = 1'b0;
    check("t5_level_refilled", 32'(fifo_level), 32'd16);
    check("t5_ready_refilled", 32'(wr_ready), 32'd0);
    errs = 0;
    for (int i = 0; i < 17; i++) begin
      b = (i == 16) ? 8'h99 : 8'(8'h20 + i);
      wait_rx("t5_rx", 100, fr, sc);
      if (fr !== frame_of(b)) errs++;
    end
    check("t5_frame_errs", errs, 32'd0);
    repeat (20) tick();

    // Asynchronous reset during bit 4 of 0x3C
    cfg_div = 32'd16; mon_div = 16;
    push_byte(8'h3C, acc);
    push_byte(8'h5A, acc);
    n = 0;
    do begin @(negedge clk); n++; end while (ser_tx !== 1'b0 && n < 50);
    repeat (5 * 16 + 8) @(negedge clk);
    check("t6_level_before", 32'(fifo_level), 32'd1);
    check("t6_busy_before", 32'(tx_busy), 32'd1);
    #2 resetn = 1'b0;
    #1;
    check("t6_rst_ser_tx", 32'(ser_tx), 32'd1);
    check("t6_rst_level", 32'(fifo_level), 32'd0);
    check("t6_rst_busy", 32'(tx_busy), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    lows = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (ser_tx !== 1'b1) lows++;
    end
    check("t6_no_residual", lows, 32'd0);
    check("t6_no_rx", 32'(rx_q.size()), 32'd0);
    check("t6_level_end", 32'(fifo_level), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
